// File: rtl/npu_mem_pkg.sv
// Shared types and memory sizing for the NPU weight/image RAM subsystem.
package npu_mem_pkg;

    // Arbiter states; HOST is reserved, host beats complete inside IDLE.
    typedef enum logic [1:0] {
        IDLE,
        HOST,
        CONV_BURST,
        DENSE_BURST
    } arb_state_t;

    // Identifies which requester issued a read beat.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_CONV,
        TAG_DENSE
    } req_tag_t;

    // Word counts of the RAM instances this arbiter can front.
    localparam int IMAGE_WORDS = 196;
    localparam int CONV_WORDS  = 55744;
    localparam int DENSE_WORDS = 37578;

endpackage

// File: rtl/npu_rd_tag_pipe.sv
// Fixed-latency shadow of the RAM read path: carries {valid, tag, last}
// alongside each issued read so returning data can be steered to its owner.
module npu_rd_tag_pipe
    import npu_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_vld_i,
    input  req_tag_t in_tag_i,
    input  logic     in_last_i,
    output logic     out_vld_o,
    output req_tag_t out_tag_o,
    output logic     out_last_o,
    output logic     any_vld_o
);

    logic     vld_q  [RD_LAT];
    req_tag_t tag_q  [RD_LAT];
    logic     last_q [RD_LAT];

    // Shift entries one stage per cycle; never stalls, reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                tag_q[i]  <= TAG_NONE;
                last_q[i] <= 1'b0;
            end
        end else begin
            vld_q[0]  <= in_vld_i;
            tag_q[0]  <= in_tag_i;
            last_q[0] <= in_last_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign out_vld_o  = vld_q[RD_LAT-1];
    assign out_tag_o  = tag_q[RD_LAT-1];
    assign out_last_o = last_q[RD_LAT-1];

    // Any stage holding a live read keeps the arbiter busy.
    always_comb begin
        any_vld_o = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            any_vld_o = any_vld_o | vld_q[i];
        end
    end

endmodule

// File: rtl/npu_ram_arbiter.sv
// Single-port RAM arbiter: host single-beat writes (highest priority) and
// round-robin conv/dense read bursts, one RAM access per cycle, with read
// data returned tagged to the issuing engine after the fixed RAM latency.
module npu_ram_arbiter
    import npu_mem_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int LW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_write,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_waitrequest,
    input  logic          conv_req,
    input  logic [AW-1:0] conv_addr,
    input  logic [LW-1:0] conv_len,
    output logic          conv_gnt,
    output logic          conv_rvalid,
    output logic          conv_last,
    input  logic          dense_req,
    input  logic [AW-1:0] dense_addr,
    input  logic [LW-1:0] dense_len,
    output logic          dense_gnt,
    output logic          dense_rvalid,
    output logic          dense_last,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    // A zero-length request still moves one beat.
    function automatic logic [LW-1:0] burst_beats(input logic [LW-1:0] len);
        return (len == '0) ? LW'(1) : len;
    endfunction

    arb_state_t    state_q;
    req_tag_t      ptr_q;
    logic [AW-1:0] cur_addr_q;
    logic [LW-1:0] cnt_q;
    logic          conv_gnt_q;
    logic          dense_gnt_q;

    logic          idle;
    logic          burst_act;
    logic          host_go;
    logic          conv_win;
    logic          dense_win;

    logic          pipe_vld;
    req_tag_t      pipe_tag;
    logic          pipe_last;
    logic          pipe_any;

    assign idle      = (state_q == IDLE);
    assign burst_act = (state_q == CONV_BURST) || (state_q == DENSE_BURST);
    assign host_go   = idle && host_write && !reset;

    // Pick a reader in IDLE when the host is quiet; the pointer only breaks ties.
    always_comb begin
        conv_win  = 1'b0;
        dense_win = 1'b0;
        if (idle && !host_write) begin
            if (conv_req && dense_req) begin
                conv_win  = (ptr_q == TAG_CONV);
                dense_win = (ptr_q != TAG_CONV);
            end else begin
                conv_win  = conv_req;
                dense_win = dense_req;
            end
        end
    end

    // Arbitration FSM: state, tie-break pointer, burst address/count and grant pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= TAG_CONV;
            cnt_q       <= '0;
            conv_gnt_q  <= 1'b0;
            dense_gnt_q <= 1'b0;
        end else begin
            conv_gnt_q  <= 1'b0;
            dense_gnt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (conv_win) begin
                        state_q    <= CONV_BURST;
                        cur_addr_q <= conv_addr;
                        cnt_q      <= burst_beats(conv_len);
                        conv_gnt_q <= 1'b1;
                        if (dense_req) ptr_q <= TAG_DENSE;
                    end else if (dense_win) begin
                        state_q     <= DENSE_BURST;
                        cur_addr_q  <= dense_addr;
                        cnt_q       <= burst_beats(dense_len);
                        dense_gnt_q <= 1'b1;
                        if (conv_req) ptr_q <= TAG_CONV;
                    end
                end
                CONV_BURST, DENSE_BURST: begin
                    cur_addr_q <= cur_addr_q + AW'(1);
                    cnt_q      <= cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_gnt         = conv_gnt_q;
    assign dense_gnt        = dense_gnt_q;
    assign host_waitrequest = reset || !idle;

    assign ram_wren = host_go;
    assign ram_data = host_go ? host_wdata : '0;
    assign ram_addr = host_go ? host_addr :
                      ((burst_act && !reset) ? cur_addr_q : '0);

    npu_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .in_vld_i   (burst_act),
        .in_tag_i   ((state_q == CONV_BURST) ? TAG_CONV : TAG_DENSE),
        .in_last_i  (cnt_q == LW'(1)),
        .out_vld_o  (pipe_vld),
        .out_tag_o  (pipe_tag),
        .out_last_o (pipe_last),
        .any_vld_o  (pipe_any)
    );

    assign conv_rvalid  = pipe_vld && (pipe_tag == TAG_CONV);
    assign dense_rvalid = pipe_vld && (pipe_tag == TAG_DENSE);
    assign conv_last    = conv_rvalid && pipe_last;
    assign dense_last   = dense_rvalid && pipe_last;
    assign rdata        = ram_q;

    assign busy = !idle || pipe_any;

endmodule

// File: tb/tb_npu_ram_arbiter.sv
// Directed bench for npu_ram_arbiter with a behavioural RAM and per-engine
// scoreboards of expected read beats.
module tb_npu_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LW = 16;
    localparam int RD_LAT = 1;

    logic          clk;
    logic          reset;
    logic          host_write;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_waitrequest;
    logic          conv_req, dense_req;
    logic [AW-1:0] conv_addr, dense_addr;
    logic [LW-1:0] conv_len, dense_len;
    logic          conv_gnt, conv_rvalid, conv_last;
    logic          dense_gnt, dense_rvalid, dense_last;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic          busy;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t conv_q[$];
    exp_t dense_q[$];

    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];

    int n_chk  = 0;
    int n_fail = 0;

    npu_ram_arbiter #(
        .AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host_write       (host_write),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_waitrequest (host_waitrequest),
        .conv_req         (conv_req),
        .conv_addr        (conv_addr),
        .conv_len         (conv_len),
        .conv_gnt         (conv_gnt),
        .conv_rvalid      (conv_rvalid),
        .conv_last        (conv_last),
        .dense_req        (dense_req),
        .dense_addr       (dense_addr),
        .dense_len        (dense_len),
        .dense_gnt        (dense_gnt),
        .dense_rvalid     (dense_rvalid),
        .dense_last       (dense_last),
        .rdata            (rdata),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data),
        .ram_wren         (ram_wren),
        .ram_q            (ram_q),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_wren === 1'b1) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drain returning beats against the scoreboards.
    always @(negedge clk) begin
        exp_t e;
        if (conv_rvalid === 1'b1) begin
            if (conv_q.size() == 0) check("conv_unexpected_rvalid", 1, 0);
            else begin
                e = conv_q.pop_front();
                check("conv_rdata", rdata, e.d);
                check("conv_last", conv_last, e.l);
            end
        end
        if (dense_rvalid === 1'b1) begin
            if (dense_q.size() == 0) check("dense_unexpected_rvalid", 1, 0);
            else begin
                e = dense_q.pop_front();
                check("dense_rdata", rdata, e.d);
                check("dense_last", dense_last, e.l);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // tag 1 = conv, 2 = dense
    task automatic push_exp(input int tag, input logic [15:0] addr, input int len);
        int n;
        logic [15:0] a;
        exp_t e;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            e.d = shadow[a];
            e.l = (i == n - 1);
            if (tag == 1) conv_q.push_back(e);
            else dense_q.push_back(e);
        end
    endtask

    // Entered on the first burst cycle; leaves on the IDLE cycle after the last beat.
    task automatic beats(input int tag, input logic [15:0] addr, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            settle();
            a = addr + 16'(i);
            check("burst_addr", ram_addr, a);
            check("burst_wren", ram_wren, 0);
            check("burst_waitreq", host_waitrequest, 1);
            check("burst_busy", busy, 1);
            if (tag == 1) begin
                check("conv_gnt", conv_gnt, (i == 0));
                check("dense_gnt_idle", dense_gnt, 0);
                if (i == 0) conv_req = 1'b0;
            end else begin
                check("dense_gnt", dense_gnt, (i == 0));
                check("conv_gnt_idle", conv_gnt, 0);
                if (i == 0) dense_req = 1'b0;
            end
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
            shadow[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        end
        reset = 1'b1;
        host_write = 0; host_addr = '0; host_wdata = '0;
        conv_req = 0; conv_addr = '0; conv_len = '0;
        dense_req = 0; dense_addr = '0; dense_len = '0;

        // Reset state
        cyc(); cyc();
        settle();
        check("rst_waitreq", host_waitrequest, 1);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_gnt", {conv_gnt, dense_gnt}, 0);
        check("rst_rvalid", {conv_rvalid, dense_rvalid, conv_last, dense_last}, 0);
        check("rst_busy", busy, 0);
        cyc();
        reset = 1'b0;

        // Host write, then read it back with a single-beat conv burst
        host_write = 1; host_addr = 16'd5; host_wdata = 8'hA5;
        settle();
        check("host_waitreq", host_waitrequest, 0);
        check("host_wren", ram_wren, 1);
        check("host_addr", ram_addr, 5);
        check("host_data", ram_data, 8'hA5);
        shadow[5] = 8'hA5;
        cyc();
        host_write = 0;
        conv_req = 1; conv_addr = 16'd5; conv_len = 16'd1;
        push_exp(1, 16'd5, 1);
        cyc();
        beats(1, 16'd5, 1);

        // Conv burst of 4
        conv_req = 1; conv_addr = 16'd100; conv_len = 16'd4;
        push_exp(1, 16'd100, 4);
        settle();
        check("arb_cycle_no_gnt", conv_gnt, 0);
        cyc();
        beats(1, 16'd100, 4);
        cyc();

        // Contention: conv, then dense, then conv again
        conv_req = 1; conv_addr = 16'd200; conv_len = 16'd2;
        dense_req = 1; dense_addr = 16'd300; dense_len = 16'd3;
        push_exp(1, 16'd200, 2);
        cyc();
        beats(1, 16'd200, 2);
        conv_req = 1;
        push_exp(2, 16'd300, 3);
        cyc();
        beats(2, 16'd300, 3);
        dense_req = 1; dense_addr = 16'd400; dense_len = 16'd1;
        push_exp(1, 16'd200, 2);
        cyc();
        beats(1, 16'd200, 2);
        push_exp(2, 16'd400, 1);
        cyc();
        beats(2, 16'd400, 1);

        // Host blocked by a dense burst of 8, then wins over a pending conv
        dense_req = 1; dense_addr = 16'd1000; dense_len = 16'd8;
        push_exp(2, 16'd1000, 8);
        cyc();
        host_write = 1; host_addr = 16'd7; host_wdata = 8'h5A;
        conv_req = 1; conv_addr = 16'd7; conv_len = 16'd1;
        beats(2, 16'd1000, 8);
        settle();
        check("blk_host_waitreq", host_waitrequest, 0);
        check("blk_host_wren", ram_wren, 1);
        check("blk_host_addr", ram_addr, 7);
        check("blk_host_data", ram_data, 8'h5A);
        shadow[7] = 8'h5A;
        push_exp(1, 16'd7, 1);
        cyc();
        host_write = 0;
        settle();
        check("blk_conv_wait_gnt", conv_gnt, 0);
        check("blk_no_wren", ram_wren, 0);
        cyc();
        beats(1, 16'd7, 1);

        // Address wrap and zero length
        conv_req = 1; conv_addr = 16'hFFFE; conv_len = 16'd3;
        push_exp(1, 16'hFFFE, 3);
        cyc();
        beats(1, 16'hFFFE, 3);
        dense_req = 1; dense_addr = 16'd42; dense_len = 16'd0;
        push_exp(2, 16'd42, 0);
        cyc();
        beats(2, 16'd42, 1);
        cyc();

        // Reset on beat 2 of a 6-beat burst
        conv_req = 1; conv_addr = 16'd50; conv_len = 16'd6;
        push_exp(1, 16'd50, 6);
        cyc();
        settle();
        check("mid_gnt", conv_gnt, 1);
        conv_req = 0;
        cyc();
        reset = 1'b1;
        cyc();
        settle();
        check("mid_rvalid", {conv_rvalid, dense_rvalid}, 0);
        check("mid_busy", busy, 0);
        check("mid_waitreq", host_waitrequest, 1);
        check("mid_dropped", conv_q.size(), 5);
        conv_q.delete();
        reset = 1'b0;
        host_write = 1; host_addr = 16'd9; host_wdata = 8'h11;
        settle();
        check("post_rst_waitreq", host_waitrequest, 0);
        check("post_rst_wren", ram_wren, 1);
        check("post_rst_addr", ram_addr, 9);
        shadow[9] = 8'h11;
        cyc();
        host_write = 0;
        settle();
        check("post_rst_rvalid", conv_rvalid, 0);
        dense_req = 1; dense_addr = 16'd9; dense_len = 16'd1;
        push_exp(2, 16'd9, 1);
        cyc();
        beats(2, 16'd9, 1);
        cyc(); cyc();

        settle();
        check("end_busy", busy, 0);
        check("end_conv_q_empty", conv_q.size(), 0);
        check("end_dense_q_empty", dense_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
